// File: rtl/fcmp_pkg.sv
// Shared definitions for the floating-point compare path.
// Contents:
//   fcmp_state_t : operand-stage FSM states
//   EXP_W, FRAC_W, SIG_W, EXP_NAN : binary32 field geometry
//   f_exp, f_frac, f_sig, f_is_nan : binary32 field extraction helpers
package fcmp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = 24;
    localparam logic [EXP_W-1:0] EXP_NAN = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUB_EXP = 2'd1,
        SUB_MAN = 2'd2,
        HOLD    = 2'd3
    } fcmp_state_t;

    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] v);
        return v[30:23];
    endfunction

    function automatic logic [FRAC_W-1:0] f_frac(input logic [31:0] v);
        return v[22:0];
    endfunction

    // Hidden bit is 1 for normals and 0 for denormals/zero.
    function automatic logic [SIG_W-1:0] f_sig(input logic [31:0] v);
        return {(f_exp(v) != '0), f_frac(v)};
    endfunction

    function automatic logic f_is_nan(input logic [31:0] v);
        return (f_exp(v) == EXP_NAN) && (f_frac(v) != '0);
    endfunction

endpackage

// File: rtl/fcmp_shared_sub.sv
// Shared 25-bit subtractor used for both the exponent and significand
// differences of the compare operand stage.
// Ports:
//   x, y : 25-bit operands
//   d    : x - y, modulo 2^25 (purely combinational)
module fcmp_shared_sub (
    input  logic [24:0] x,
    input  logic [24:0] y,
    output logic [24:0] d
);

    assign d = x - y;

endmodule

// File: rtl/fcmp_operand_stage.sv
// Sequential front end of the floating-point compare path. Accepts two
// binary32 operands, computes the exponent difference and then (only when
// exponents match) the significand difference on one shared subtractor,
// and holds the results until downstream accepts.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, in_ready    : operand handshake (in_ready only in IDLE)
//   a, b                  : binary32 operands
//   out_valid, out_ready  : result handshake (out_valid only in HOLD)
//   a_q, b_q              : latched operands
//   exp_diff              : {0,a_exp}-{0,b_exp}, bit 8 is the borrow
//   mantissa_res          : {0,a_sig}-{0,b_sig}, bit 24 is the borrow
//   unordered             : either operand is NaN
//   zeros_equal           : both operands are +/-0
module fcmp_operand_stage
    import fcmp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_q,
    output logic [31:0] b_q,
    output logic [8:0]  exp_diff,
    output logic [24:0] mantissa_res,
    output logic        unordered,
    output logic        zeros_equal
);

    fcmp_state_t state, state_next;
    logic [24:0] sub_x, sub_y, sub_d;

    fcmp_shared_sub u_sub (
        .x (sub_x),
        .y (sub_y),
        .d (sub_d)
    );

    // Significands only while in SUB_MAN; exponents otherwise.
    always_comb begin
        sub_x = {{(25-EXP_W){1'b0}}, f_exp(a_q)};
        sub_y = {{(25-EXP_W){1'b0}}, f_exp(b_q)};
        if (state == SUB_MAN) begin
            sub_x = {1'b0, f_sig(a_q)};
            sub_y = {1'b0, f_sig(b_q)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SUB_EXP;
            // Unequal exponents decide the compare; skip the mantissa pass.
            SUB_EXP: state_next = (sub_d[EXP_W-1:0] != '0) ? HOLD : SUB_MAN;
            SUB_MAN: state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            exp_diff     <= '0;
            mantissa_res <= '0;
            unordered    <= 1'b0;
            zeros_equal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q          <= a;
                        b_q          <= b;
                        exp_diff     <= '0;
                        mantissa_res <= '0;
                        unordered    <= 1'b0;
                        zeros_equal  <= 1'b0;
                    end
                end
                SUB_EXP: begin
                    exp_diff    <= sub_d[8:0];
                    unordered   <= f_is_nan(a_q) || f_is_nan(b_q);
                    zeros_equal <= (a_q[30:0] == '0) && (b_q[30:0] == '0);
                end
                SUB_MAN: begin
                    mantissa_res <= sub_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fcmp_operand_stage.md
# fcmp_operand_stage

Sequential front end of the floating-point compare path. Accepts two IEEE-754 single-precision operands over a valid/ready handshake and computes the exponent difference and signed mantissa difference on one shared 25-bit subtractor, one field per cycle. Presents the latched operands, both differences and two special-case flags to the downstream magnitude/sign compare stage, holding them until that stage accepts.

## Interface
- No parameters; widths are fixed by binary32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: stage can accept; `(state == IDLE)`.
- `a`, `b` in 32 each: binary32 operands.
- `out_valid` out 1: results valid.
- `out_ready` in 1: downstream accepts.
- `a_q`, `b_q` out 32 each: latched operands.
- `exp_diff` out 9: `{1'b0,a_exp} - {1'b0,b_exp}`; bit 8 is the borrow.
- `mantissa_res` out 25: `{1'b0,a_sig} - {1'b0,b_sig}`; bit 24 is the borrow. `sig` is `{hidden,frac[22:0]}`, with `hidden = (exp != 0)`.
- `unordered` out 1: either operand is NaN (`exp == 8'hFF` and `frac != 0`).
- `zeros_equal` out 1: both operands are ±0 (`a[30:0] == 0` and `b[30:0] == 0`).

## Operation
- FSM states: IDLE, SUB_EXP, SUB_MAN, HOLD.
- IDLE: on `in_valid && in_ready`, latch `a` and `b` into `a_q`/`b_q`, clear `exp_diff`, `mantissa_res` and both flags, then go to SUB_EXP.
- SUB_EXP:
  - Drive the subtractor with zero-extended exponents and register the low 9 bits into `exp_diff`.
  - Register `unordered` and `zeros_equal`.
  - If `exp_diff[7:0] != 0`, go straight to HOLD with `mantissa_res = 0`; the mantissa is irrelevant to downstream.
  - Otherwise go to SUB_MAN.
- SUB_MAN: drive the subtractor with the 25-bit zero-extended significands, register `mantissa_res`, go to HOLD.
- HOLD:
  - `out_valid = 1`; all outputs are stable.
  - On `out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; the upstream producer holds its data until `in_ready`.
- Arithmetic:
  - Two's complement, modulo 2^25; the exponent result is the low 9 bits.
  - No normalisation or rounding.
  - Denormals use hidden bit 0.
- Sign bits are not processed; they pass through in `a_q`/`b_q`.

## Timing
- Acceptance edge T0.
  - Unequal exponents: `out_valid` rises after edge T1 (2-cycle latency).
  - Equal exponents: `out_valid` rises after edge T2 (3-cycle latency).
- `out_valid` is a registered state decode, with no combinational path from `out_ready`.
- `in_ready` is combinational from state, with no path from `in_valid`.
- Throughput: one result per 3 or 4 cycles; no overlap between operations.
- On the HOLD edge where `out_ready = 1`, the state returns to IDLE. `in_ready` rises the following cycle; there is no same-cycle re-accept.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `a_q`, `b_q`, `exp_diff`, `mantissa_res`, `unordered`, `zeros_equal` and `out_valid` all go to 0.
  - `in_ready` reads 1, but no acceptance occurs while `rst_n` is low.
- Reset mid-operation discards the in-flight pair; no partial result is emitted.
- Exponents equal with all-zero fractions still go through SUB_MAN, giving `mantissa_res = 0`.

## Structure
- `fcmp_pkg` holds:
  - the state enum `fcmp_state_t`;
  - localparams `EXP_W = 8`, `FRAC_W = 23`, `SIG_W = 24`, `EXP_NAN = 8'hFF`;
  - field-extract functions `f_exp`, `f_frac`, `f_sig`, `f_is_nan`.
- The shared subtractor is sub-module `fcmp_shared_sub`: 25-bit operands `x`, `y`, output `d = x - y`, purely combinational.
- The operand mux (exponent vs significand) lives in `fcmp_operand_stage`, selected by state.

## Test plan
- 1.0 vs 2.0: `a = 0x3F800000`, `b = 0x40000000` → `exp_diff = 0x1FF`, `mantissa_res = 0`, `out_valid` 2 cycles after accept, SUB_MAN never entered.
- 1.5 vs 1.0: `a = 0x3FC00000`, `b = 0x3F800000` → `exp_diff = 0x000`, `mantissa_res = 0x0400000`, latency 3.
- 1.0 vs 1.5: `a = 0x3F800000`, `b = 0x3FC00000` → `exp_diff = 0x000`, `mantissa_res = 0x1C00000` (borrow set).
- NaN and zeros:
  - `a = 0x7FC00000`, `b = 0x3F800000` → `unordered = 1`, `exp_diff = 0x080`.
  - `a = 0x00000000`, `b = 0x80000000` → `zeros_equal = 1`, `exp_diff = 0`, `mantissa_res = 0`.
- Backpressure: hold `out_ready = 0` for 5 cycles in HOLD → all outputs stable, `in_ready = 0`, a new `in_valid` is ignored. On release, IDLE follows next cycle and the next pair is accepted.
- Reset mid-op: assert `rst_n = 0` during SUB_MAN → all outputs are 0 immediately (asynchronous). After release, accept a new pair and get correct results with no stale `out_valid`.
